// File: rtl/nihilist_pkg.sv
// Shared types, constants and Polybius helpers for the Nihilist stream cipher.
package nihilist_pkg;

  typedef logic [1:0] state_t;
  localparam state_t S_NOKEY = 2'd0;
  localparam state_t S_IDLE  = 2'd1;
  localparam state_t S_MSG   = 2'd2;

  // Index 0 is row 1 col 1; the literal is written last-cell-first so 'M' lands at index 0
  typedef logic [24:0][7:0] square_t;
  localparam square_t DEFAULT_SQUARE = "ZYXWVUTSRQPONLKGFEDCBAHIM";

  typedef logic [7:0] cell_num_t;

  localparam logic [7:0] ERR_ENC_BYTE = 8'h00;
  localparam logic [7:0] ERR_DEC_BYTE = 8'h3F;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } cell_t;

  // Lowest matching index wins if a rewritten square holds a duplicate char
  function automatic cell_t find_cell(input square_t sq, input logic [7:0] ch);
    cell_t res;
    res = '0;
    for (int i = 24; i >= 0; i--) begin
      if (sq[i] == ch) begin
        res.hit = 1'b1;
        res.row = 3'(i / 5 + 1);
        res.col = 3'(i % 5 + 1);
      end
    end
    return res;
  endfunction

  function automatic logic in_square(input square_t sq, input logic [7:0] ch);
    logic res;
    res = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (sq[i] == ch) res = 1'b1;
    end
    return res;
  endfunction

  function automatic cell_num_t cell_num(input logic [2:0] row, input logic [2:0] col);
    return cell_num_t'(row) * 8'd10 + cell_num_t'(col);
  endfunction

endpackage

// File: rtl/polybius_lookup.sv
// Combinational Polybius square lookups: char -> (hit, row, col) and (row, col) -> char.
module polybius_lookup
  import nihilist_pkg::*;
(
  input  square_t    square,
  input  logic [7:0] find_char,
  output logic       hit,
  output logic [2:0] row,
  output logic [2:0] col,
  input  logic [2:0] cell_row,
  input  logic [2:0] cell_col,
  output logic [7:0] cell_char
);

  cell_t      found;
  logic [5:0] cell_idx;

  always_comb begin
    found = find_cell(square, find_char);
    hit   = found.hit;
    row   = found.row;
    col   = found.col;
  end

  // Coordinates outside the square yield '?' instead of indexing past the array
  always_comb begin
    cell_idx  = 6'(cell_row) * 6'd5 + 6'(cell_col) - 6'd6;
    cell_char = ERR_DEC_BYTE;
    if (cell_idx <= 6'd24) cell_char = square[cell_idx[4:0]];
  end

endmodule

// File: rtl/nihilist_stream_cipher.sv
// Streaming runtime-keyed Nihilist encrypt/decrypt engine with a two-stage pipeline.
// Define NIHILIST_SQUARE_WR_EN to make the Polybius square rewritable at runtime.
module nihilist_stream_cipher
  import nihilist_pkg::*;
#(
  parameter  int KEY_MAX_LEN = 16,
  localparam int KIDX_W      = $clog2(KEY_MAX_LEN) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_clr,
  input  logic       key_wr_en,
  input  logic [7:0] key_wr_data,
  output logic       key_err,
  input  logic       mode,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       m_err,
  output logic       busy
`ifdef NIHILIST_SQUARE_WR_EN
  ,
  input  logic       sq_wr_en,
  input  logic [4:0] sq_wr_addr,
  input  logic [7:0] sq_wr_data
`endif
);

  state_t            state;
  logic [7:0]        key_mem [KEY_MAX_LEN];
  logic [KIDX_W-1:0] key_len;
  logic [KIDX_W-1:0] kidx;
  logic              msg_mode;
  square_t           square;
  logic              sq_wr_bad;

  logic beat, start_msg, clr_ok, wr_ok, key_bad, eff_mode;
  logic adv1, adv2, v1, v2;

`ifdef NIHILIST_SQUARE_WR_EN
  logic sq_wr_ok;
  assign sq_wr_ok  = sq_wr_en && !busy && (sq_wr_addr <= 5'd24);
  assign sq_wr_bad = sq_wr_en && !sq_wr_ok;

  always_ff @(posedge clk) begin
    if (rst) square <= DEFAULT_SQUARE;
    else if (sq_wr_ok) square[sq_wr_addr] <= sq_wr_data;
  end
`else
  assign square    = DEFAULT_SQUARE;
  assign sq_wr_bad = 1'b0;
`endif

  assign adv2     = !v2 || m_ready;
  assign adv1     = !v1 || adv2;
  assign s_ready  = (state != S_NOKEY) && adv1;
  assign beat     = s_valid && s_ready;
  assign m_valid  = v2;
  assign busy     = (state == S_MSG) || v1 || v2;
  assign eff_mode = (state == S_IDLE) ? mode : msg_mode;

  // A beat starting a message in S_IDLE outranks a same-cycle key clear
  assign start_msg = beat && (state == S_IDLE);
  assign clr_ok    = key_clr && ((state == S_NOKEY) || ((state == S_IDLE) && !beat));
  assign wr_ok     = key_wr_en && !key_clr && (state != S_MSG) &&
                     in_square(square, key_wr_data) && (key_len != KIDX_W'(KEY_MAX_LEN));
  assign key_bad   = (key_wr_en && !key_clr && !wr_ok) || (key_clr && !clr_ok) || sq_wr_bad;

  always_ff @(posedge clk) begin
    if (wr_ok) key_mem[key_len[KIDX_W-2:0]] <= key_wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_NOKEY;
      key_len  <= '0;
      kidx     <= '0;
      msg_mode <= 1'b0;
      key_err  <= 1'b0;
    end else begin
      key_err <= key_bad;
      if (clr_ok) key_len <= '0;
      else if (wr_ok) key_len <= key_len + 1'b1;
      if (start_msg) msg_mode <= mode;
      if (beat) begin
        if (s_last || (KIDX_W'(kidx + 1'b1) == key_len)) kidx <= '0;
        else kidx <= kidx + 1'b1;
      end
      case (state)
        S_NOKEY: if (wr_ok) state <= S_IDLE;
        S_IDLE: begin
          if (start_msg) begin
            if (!s_last) state <= S_MSG;
          end else if (clr_ok) begin
            state <= S_NOKEY;
          end
        end
        S_MSG:   if (beat && s_last) state <= S_IDLE;
        default: state <= S_NOKEY;
      endcase
    end
  end

  logic       d_hit, k_hit;
  logic [2:0] d_row, d_col, k_row, k_col;
  logic [2:0] dec_row, dec_col;
  logic [7:0] dec_char, key_char, key_cell_unused;

  assign key_char = key_mem[kidx[KIDX_W-2:0]];

  polybius_lookup u_data_lookup (
    .square   (square),
    .find_char(s_data),
    .hit      (d_hit),
    .row      (d_row),
    .col      (d_col),
    .cell_row (dec_row),
    .cell_col (dec_col),
    .cell_char(dec_char)
  );

  polybius_lookup u_key_lookup (
    .square   (square),
    .find_char(key_char),
    .hit      (k_hit),
    .row      (k_row),
    .col      (k_col),
    .cell_row (3'd0),
    .cell_col (3'd0),
    .cell_char(key_cell_unused)
  );

  logic       mode1, last1, dhit1, khit1;
  logic [7:0] data1;
  logic [2:0] drow1, dcol1, krow1, kcol1;

  cell_num_t  knum, dnum, enc_sum;
  logic [8:0] diff;
  logic [7:0] tens, units;
  logic       dec_ok, enc_ok;
  logic [7:0] s2_data;
  logic       s2_err;

  // Decrypt recovers the square cell from the decimal digits of the difference
  always_comb begin
    knum    = cell_num(krow1, kcol1);
    dnum    = cell_num(drow1, dcol1);
    enc_sum = dnum + knum;
    enc_ok  = dhit1 && khit1;
    diff    = {1'b0, data1} - {1'b0, knum};
    tens    = diff[7:0] / 8'd10;
    units   = diff[7:0] % 8'd10;
    dec_ok  = khit1 && !diff[8] && (tens >= 8'd1) && (tens <= 8'd5) &&
              (units >= 8'd1) && (units <= 8'd5);
    dec_row = tens[2:0];
    dec_col = units[2:0];
    if (mode1) begin
      s2_data = dec_ok ? dec_char : ERR_DEC_BYTE;
      s2_err  = !dec_ok;
    end else begin
      s2_data = enc_ok ? enc_sum : ERR_ENC_BYTE;
      s2_err  = !enc_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      mode1  <= 1'b0;
      last1  <= 1'b0;
      dhit1  <= 1'b0;
      khit1  <= 1'b0;
      data1  <= '0;
      drow1  <= '0;
      dcol1  <= '0;
      krow1  <= '0;
      kcol1  <= '0;
      m_data <= '0;
      m_last <= 1'b0;
      m_err  <= 1'b0;
    end else begin
      if (adv1) begin
        v1 <= beat;
        if (beat) begin
          mode1 <= eff_mode;
          last1 <= s_last;
          data1 <= s_data;
          dhit1 <= d_hit;
          drow1 <= d_row;
          dcol1 <= d_col;
          khit1 <= k_hit;
          krow1 <= k_row;
          kcol1 <= k_col;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          m_data <= s2_data;
          m_last <= last1;
          m_err  <= s2_err;
        end
      end
    end
  end

endmodule
